spi_reg_ctrl: RTL and testbench

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_pkg.sv | 24 ++
 rtl/spi_reg_timeout.sv | 41 ++++
 rtl/spi_reg_ctrl.sv | 158 +++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared types and constants for the SPI register bridge
// Purpose: FSM state encoding, command byte layout and address width used by
//          spi_reg_ctrl and its testbench.
// Ports:   none (package).
package spi_reg_pkg;

  localparam int ADDR_W     = 7;
  localparam int CMD_RD_BIT = 7;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_DATA,
    WR_BUS,
    RD_BUS,
    RD_WAIT
  } state_t;

  // Register addresses wrap at the top of the 7-bit space.
  function automatic logic [ADDR_W-1:0] addr_incr(input logic [ADDR_W-1:0] a);
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/spi_reg_timeout.sv
// rtl/spi_reg_timeout.sv - register-bus acknowledge timeout counter
// Purpose: counts cycles of an outstanding register access; expire is high
//          during the ACK_TIMEOUT-th cycle since start.
// Ports:   clk, rst (sync, active-high)
//          start  - begin counting from zero (access issued)
//          clear  - stop and zero the counter (access finished or abandoned)
//          expire - access has been outstanding for ACK_TIMEOUT cycles
module spi_reg_timeout #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          active;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The owner clears on expire, so cnt never runs past ACK_TIMEOUT-1.
  assign expire = active && (cnt == CW'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI slave byte stream to register bus bridge
// Purpose: first byte of each SPI transaction is a command (bit7 read,
//          bits[6:0] address); following bytes write registers or clock out
//          register read data on MISO.
// Config:  SPI_REG_CTRL_AUTOINC_EN - defined: address increments (mod 128)
//          after each access; undefined: address fixed for the transaction.
// Ports:   clk, rst (sync, active-high)
//          spi_data_out/spi_data_stb - received byte and its valid pulse
//          spi_tsx_start             - chip-select assertion pulse
//          spi_data_in               - next byte shifted out on MISO
//          reg_addr/reg_wdata/reg_we/reg_re/reg_rdata/reg_ack - register bus
//          busy, err_overrun, err_timeout (sticky), err_clr
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE   = 8'h00,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        spi_data_out,
  input  logic              spi_data_stb,
  input  logic              spi_tsx_start,
  output logic [7:0]        spi_data_in,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  input  logic              reg_ack,
  output logic              busy,
  output logic              err_overrun,
  output logic              err_timeout,
  input  logic              err_clr
);

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_d, addr_adv;
  logic [7:0]        wdata_d, din_d;
  logic              we_d, re_d;
  logic              ovr_set, to_set;
  logic              tmr_start, tmr_clear, tmr_expire;

`ifdef SPI_REG_CTRL_AUTOINC_EN
  assign addr_adv = addr_incr(reg_addr);
`else
  assign addr_adv = reg_addr;
`endif

  spi_reg_timeout #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .start  (tmr_start),
    .clear  (tmr_clear),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      spi_data_in <= IDLE_BYTE;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      spi_data_in <= din_d;
      reg_addr    <= addr_d;
      reg_wdata   <= wdata_d;
      reg_we      <= we_d;
      reg_re      <= re_d;
      // Sticky flags; a new error in the clearing cycle survives.
      err_overrun <= ovr_set | (err_overrun & ~err_clr);
      err_timeout <= to_set  | (err_timeout & ~err_clr);
    end
  end

  always_comb begin
    state_d   = state;
    addr_d    = reg_addr;
    wdata_d   = reg_wdata;
    we_d      = reg_we;
    re_d      = reg_re;
    din_d     = spi_data_in;
    ovr_set   = 1'b0;
    to_set    = 1'b0;
    tmr_start = 1'b0;
    tmr_clear = 1'b0;

    if (spi_tsx_start) begin
      // Abandon whatever was in flight; a late reg_ack lands in CMD and is ignored.
      state_d   = CMD;
      we_d      = 1'b0;
      re_d      = 1'b0;
      din_d     = IDLE_BYTE;
      tmr_clear = 1'b1;
    end else begin
      case (state)
        CMD: begin
          if (spi_data_stb) begin
            addr_d = spi_data_out[ADDR_W-1:0];
            if (spi_data_out[CMD_RD_BIT]) begin
              re_d      = 1'b1;
              state_d   = RD_BUS;
              tmr_start = 1'b1;
            end else begin
              state_d = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (spi_data_stb) begin
            wdata_d   = spi_data_out;
            we_d      = 1'b1;
            state_d   = WR_BUS;
            tmr_start = 1'b1;
          end
        end
        WR_BUS: begin
          ovr_set = spi_data_stb;
          if (reg_ack || tmr_expire) begin
            we_d      = 1'b0;
            addr_d    = addr_adv;
            state_d   = WR_DATA;
            tmr_clear = 1'b1;
            to_set    = !reg_ack;
          end
        end
        RD_BUS: begin
          ovr_set = spi_data_stb;
          if (reg_ack || tmr_expire) begin
            re_d      = 1'b0;
            din_d     = reg_ack ? reg_rdata : IDLE_BYTE;
            addr_d    = addr_adv;
            state_d   = RD_WAIT;
            tmr_clear = 1'b1;
            to_set    = !reg_ack;
          end
        end
        RD_WAIT: begin
          // The byte just received is a dummy; its arrival means MISO data was consumed.
          if (spi_data_stb) begin
            re_d      = 1'b1;
            state_d   = RD_BUS;
            tmr_start = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - self-checking bench for spi_reg_ctrl
module tb_spi_reg_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] spi_data_out;
  logic       spi_data_stb;
  logic       spi_tsx_start;
  logic [7:0] spi_data_in;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       reg_ack;
  logic       busy;
  logic       err_overrun;
  logic       err_timeout;
  logic       err_clr;

  spi_reg_ctrl #(.IDLE_BYTE(8'h00), .ACK_TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .spi_data_out  (spi_data_out),
    .spi_data_stb  (spi_data_stb),
    .spi_tsx_start (spi_tsx_start),
    .spi_data_in   (spi_data_in),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_we        (reg_we),
    .reg_re        (reg_re),
    .reg_rdata     (reg_rdata),
    .reg_ack       (reg_ack),
    .busy          (busy),
    .err_overrun   (err_overrun),
    .err_timeout   (err_timeout),
    .err_clr       (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] dev_mem [128];
  logic [7:0] ref_mem [128];
  logic [6:0] wlog_a [$];
  logic [7:0] wlog_d [$];
  logic [6:0] rlog_a [$];
  int ack_delay = 2;
  int force_req = 0;
  int overlap   = 0;

  function automatic logic [6:0] m_adv(input logic [6:0] a);
`ifdef SPI_REG_CTRL_AUTOINC_EN
    return 7'((int'(a) + 1) % 128);
`else
    return a;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tsx();
    spi_tsx_start = 1'b1;
    tick();
    spi_tsx_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_data_out = b;
    spi_data_stb = 1'b1;
    tick();
    spi_data_stb = 1'b0;
  endtask

  task automatic wait_bus();
    int n = 0;
    while ((reg_we || reg_re) && n < 60) begin
      tick();
      n++;
    end
    if (reg_we || reg_re) begin
      n_vec++;
      n_bad++;
      $display("FAIL bus_wait: request still pending after %0d cycles, required to end", n);
    end
  endtask

  task automatic clear_logs();
    wlog_a.delete();
    wlog_d.delete();
    rlog_a.delete();
  endtask

  // Register-bus device: acks after ack_delay cycles (0 = never), records accesses.
  initial begin
    int age = 0;
    int force_seen = 0;
    reg_ack   = 1'b0;
    reg_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (reg_we && reg_re) overlap++;
      if (force_req != force_seen) begin
        force_seen = force_req;
        reg_ack    = 1'b1;
      end else if ((reg_we || reg_re) && !reg_ack) begin
        age++;
        if (ack_delay != 0 && age >= ack_delay) begin
          reg_ack   = 1'b1;
          reg_rdata = dev_mem[reg_addr];
          if (reg_we) begin
            dev_mem[reg_addr] = reg_wdata;
            wlog_a.push_back(reg_addr);
            wlog_d.push_back(reg_wdata);
          end
          if (reg_re) rlog_a.push_back(reg_addr);
          age = 0;
        end
      end else begin
        reg_ack = 1'b0;
        age     = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] cmd;
    int         n;
    logic [7:0] d0, d1;
    logic [6:0] ea0, ea1;
    logic [7:0] ev0, ev1;
  } vec_t;

  vec_t vecs[3];

  initial begin
    logic [6:0] a, sa;
    logic [7:0] b;
    logic       rd;
    int         cnt, n;
    logic [6:0] exp_a [$];
    logic [7:0] exp_d [$];

    vecs[0] = '{8'h05, 2, 8'hA1, 8'hB2, 7'h05, m_adv(7'h05), 8'hA1, 8'hB2};
    vecs[1] = '{8'h90, 2, 8'h00, 8'h00, 7'h10, m_adv(7'h10), 8'h3C,
                (m_adv(7'h10) == 7'h11) ? 8'h4D : 8'h3C};
    vecs[2] = '{8'h7F, 2, 8'h5A, 8'h6B, 7'h7F, m_adv(7'h7F), 8'h5A, 8'h6B};

    for (int i = 0; i < 128; i++) dev_mem[i] = 8'($urandom);
    dev_mem[7'h10] = 8'h3C;
    dev_mem[7'h11] = 8'h4D;
    dev_mem[7'h01] = 8'hE7;

    rst = 1'b1; spi_data_out = 8'h00; spi_data_stb = 1'b0;
    spi_tsx_start = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    chk("rst_data_in", spi_data_in, 8'h00);
    chk("rst_addr", reg_addr, 7'h00);
    chk("rst_wdata", reg_wdata, 8'h00);
    chk("rst_we", reg_we, 1'b0);
    chk("rst_re", reg_re, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_ovr", err_overrun, 1'b0);
    chk("rst_err_to", err_timeout, 1'b0);
    rst = 1'b0;
    tick();

    // Bytes outside a transaction are ignored.
    send_byte(8'h85);
    tick();
    chk("idle_stb_busy", busy, 1'b0);
    chk("idle_stb_re", reg_re, 1'b0);

    // Directed transactions.
    ack_delay = 2;
    for (int v = 0; v < 3; v++) begin
      clear_logs();
      pulse_tsx();
      send_byte(vecs[v].cmd);
      if (!vecs[v].cmd[7]) begin
        for (int k = 0; k < vecs[v].n; k++) begin
          send_byte(k == 0 ? vecs[v].d0 : vecs[v].d1);
          wait_bus();
        end
        chk("vec_wr_count", wlog_a.size(), vecs[v].n);
        if (wlog_a.size() >= 2) begin
          chk("vec_wr_addr0", wlog_a[0], vecs[v].ea0);
          chk("vec_wr_data0", wlog_d[0], vecs[v].ev0);
          chk("vec_wr_addr1", wlog_a[1], vecs[v].ea1);
          chk("vec_wr_data1", wlog_d[1], vecs[v].ev1);
        end
      end else begin
        wait_bus();
        chk("vec_rd_data0", spi_data_in, vecs[v].ev0);
        send_byte(8'hEE);
        wait_bus();
        chk("vec_rd_data1", spi_data_in, vecs[v].ev1);
        chk("vec_rd_count", rlog_a.size(), 2);
        if (rlog_a.size() >= 2) begin
          chk("vec_rd_addr0", rlog_a[0], vecs[v].ea0);
          chk("vec_rd_addr1", rlog_a[1], vecs[v].ea1);
        end
      end
    end
    chk("vec_err_ovr", err_overrun, 1'b0);
    chk("vec_err_to", err_timeout, 1'b0);

    // Timeout: first read acks, second is never acked.
    ack_delay = 1;
    pulse_tsx();
    send_byte(8'h81);
    wait_bus();
    chk("to_first_read", spi_data_in, 8'hE7);
    ack_delay = 0;
    send_byte(8'h00);
    cnt = 0;
    while (reg_re && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("to_re_cycles", cnt, 16);
    chk("to_err_flag", err_timeout, 1'b1);
    chk("to_data_in", spi_data_in, 8'h00);
    chk("to_addr_adv", reg_addr, m_adv(m_adv(7'h01)));
    chk("to_busy", busy, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_clr", err_timeout, 1'b0);

    // Overrun: second byte while the write is pending; error set while clearing.
    ack_delay = 0;
    clear_logs();
    pulse_tsx();
    send_byte(8'h20);
    send_byte(8'h11);
    tick();
    spi_data_out = 8'h22; spi_data_stb = 1'b1; err_clr = 1'b1;
    tick();
    spi_data_stb = 1'b0; err_clr = 1'b0;
    chk("ovr_flag_set_wins", err_overrun, 1'b1);
    chk("ovr_wdata_held", reg_wdata, 8'h11);
    chk("ovr_we_held", reg_we, 1'b1);
    ack_delay = 1;
    wait_bus();
    repeat (3) tick();
    chk("ovr_wr_count", wlog_a.size(), 1);
    if (wlog_a.size() == 1) begin
      chk("ovr_wr_addr", wlog_a[0], 7'h20);
      chk("ovr_wr_data", wlog_d[0], 8'h11);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovr_clr", err_overrun, 1'b0);

    // Abort a pending read with a new chip select; the late ack must be ignored.
    ack_delay = 1;
    pulse_tsx();
    send_byte(8'h90);
    wait_bus();
    chk("abort_pre_data", spi_data_in, 8'h3C);
    ack_delay = 0;
    send_byte(8'hFF);
    tick();
    pulse_tsx();
    chk("abort_re_drop", reg_re, 1'b0);
    chk("abort_data_idle", spi_data_in, 8'h00);
    chk("abort_busy", busy, 1'b1);
    force_req++;
    repeat (3) tick();
    chk("abort_late_ack_data", spi_data_in, 8'h00);
    chk("abort_late_ack_re", reg_re, 1'b0);
    clear_logs();
    ack_delay = 1;
    send_byte(8'h03);
    send_byte(8'h44);
    wait_bus();
    chk("abort_cmd_count", wlog_a.size(), 1);
    if (wlog_a.size() == 1) begin
      chk("abort_cmd_addr", wlog_a[0], 7'h03);
      chk("abort_cmd_data", wlog_d[0], 8'h44);
    end

    // Reset in the middle of a pending write.
    ack_delay = 0;
    clear_logs();
    pulse_tsx();
    send_byte(8'h05);
    send_byte(8'h77);
    chk("rstmid_we_pre", reg_we, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_we", reg_we, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_wdata", reg_wdata, 8'h00);
    force_req++;
    repeat (3) tick();
    chk("rstmid_we_after_ack", reg_we, 1'b0);
    chk("rstmid_busy_after_ack", busy, 1'b0);

    // Random transactions against a register-array model.
    for (int i = 0; i < 128; i++) ref_mem[i] = dev_mem[i];
    for (int t = 0; t < 25; t++) begin
      rd        = 1'($urandom_range(0, 1));
      sa        = ($urandom_range(0, 3) == 0) ? 7'h7E : 7'($urandom);
      n         = $urandom_range(1, 4);
      ack_delay = $urandom_range(1, 5);
      clear_logs();
      exp_a.delete();
      exp_d.delete();
      pulse_tsx();
      send_byte({rd, sa});
      a = sa;
      if (rd) begin
        for (int k = 0; k < n; k++) begin
          if (k > 0) send_byte(8'($urandom));
          wait_bus();
          chk("rnd_rdata", spi_data_in, ref_mem[a]);
          if (rlog_a.size() > k) chk("rnd_raddr", rlog_a[k], a);
          a = m_adv(a);
        end
        chk("rnd_rcount", rlog_a.size(), n);
      end else begin
        for (int k = 0; k < n; k++) begin
          b = 8'($urandom);
          send_byte(b);
          wait_bus();
          ref_mem[a] = b;
          exp_a.push_back(a);
          exp_d.push_back(b);
          a = m_adv(a);
        end
        chk("rnd_wcount", wlog_a.size(), n);
        for (int k = 0; k < n && k < wlog_a.size(); k++) begin
          chk("rnd_waddr", wlog_a[k], exp_a[k]);
          chk("rnd_wdata", wlog_d[k], exp_d[k]);
        end
      end
    end
    chk("rnd_err_flags", {err_overrun, err_timeout}, 2'b00);
    chk("we_re_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
